// File: rtl/operand_fetch_ctrl_pkg.sv
// Shared state encoding and default widths for the operand fetch sequencer.
package operand_fetch_ctrl_pkg;

    localparam int OFC_DATA_W = 32;
    localparam int OFC_ADDR_W = 3;
    localparam int OFC_OP_W   = 4;
    localparam int OFC_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_A  = 2'd1,
        RD_B  = 2'd2,
        VALID = 2'd3
    } ofc_state_t;

endpackage

// File: rtl/operand_fetch_ctrl.sv
// Reads operands A and B from the combinational operand memory and hands {A, B, op} to the ALU.
// Latency 2 cycles from accept to out_valid_o (1 cycle for equal addresses); out_valid_o holds until out_ready_i.
module operand_fetch_ctrl
    import operand_fetch_ctrl_pkg::*;
#(
    parameter int DATA_W = OFC_DATA_W,
    parameter int ADDR_W = OFC_ADDR_W,
    parameter int OP_W   = OFC_OP_W,
    parameter int CNT_W  = OFC_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_a_i,
    input  logic [ADDR_W-1:0] req_addr_b_i,
    input  logic [OP_W-1:0]   req_op_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_dato_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_a_o,
    output logic [DATA_W-1:0] out_b_o,
    output logic [OP_W-1:0]   out_op_o,
    output logic [CNT_W-1:0]  done_cnt_o
);

    ofc_state_t        state_q;
    logic [ADDR_W-1:0] addr_a_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              handshake;
    logic              accept;

    // VALID with a taking ALU frees the slot in the same cycle, so a new request can chain in.
    assign req_ready_o = rst_ni && ((state_q == IDLE) || ((state_q == VALID) && out_ready_i));
    assign accept      = req_valid_i && req_ready_o;
    assign handshake   = valid_q && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            mem_addr_q <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_a_q   <= req_addr_a_i;
                        addr_b_q   <= req_addr_b_i;
                        op_q       <= req_op_i;
                        mem_addr_q <= req_addr_a_i;
                        state_q    <= RD_A;
                    end
                end
                RD_A: begin
                    a_q <= mem_dato_i;
                    // Same address for both operands: one read serves both, skip RD_B.
                    if (addr_a_q == addr_b_q) begin
                        b_q        <= mem_dato_i;
                        mem_addr_q <= '0;
                        valid_q    <= 1'b1;
                        state_q    <= VALID;
                    end else begin
                        mem_addr_q <= addr_b_q;
                        state_q    <= RD_B;
                    end
                end
                RD_B: begin
                    b_q        <= mem_dato_i;
                    mem_addr_q <= '0;
                    valid_q    <= 1'b1;
                    state_q    <= VALID;
                end
                VALID: begin
                    if (out_ready_i) begin
                        valid_q <= 1'b0;
                        if (req_valid_i) begin
                            addr_a_q   <= req_addr_a_i;
                            addr_b_q   <= req_addr_b_i;
                            op_q       <= req_op_i;
                            mem_addr_q <= req_addr_a_i;
                            state_q    <= RD_A;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    mem_addr_q <= '0;
                    valid_q    <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (handshake) begin
            cnt_q <= cnt_d;
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign out_valid_o = valid_q;
    assign out_a_o     = a_q;
    assign out_b_o     = b_q;
    assign out_op_o    = op_q;
    assign done_cnt_o  = cnt_q;

endmodule

// File: doc/operand_fetch_ctrl.md
Name: operand_fetch_ctrl

Overview:
- Sequencer that sits directly downstream of the 8x32 combinational operand memory and upstream of the ALU.
- Accepts a request carrying two operand addresses and an opcode, then reads operand A and operand B from the memory over successive cycles.
- Presents the {A, B, op} bundle to the ALU under a valid/ready handshake.
- Counts completed transactions.

Parameters:
- DATA_W, 32: operand width; matches the memory word.
- ADDR_W, 3: memory address width; 8 words.
- OP_W, 4: ALU opcode width; passed through unchanged.
- CNT_W, 8: width of the completed-transaction counter.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_ni  in  1  synchronous, active-low reset, sampled on the rising edge of clk_i.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  controller can accept a request this cycle.
- req_addr_a_i  in  ADDR_W  address of operand A.
- req_addr_b_i  in  ADDR_W  address of operand B.
- req_op_i  in  OP_W  opcode to forward.
- mem_addr_o  out  ADDR_W  address driven to the operand memory.
- mem_dato_i  in  DATA_W  combinational read data from the memory.
- out_valid_o  out  1  operand bundle valid.
- out_ready_i  in  1  ALU accepts the bundle.
- out_a_o  out  DATA_W  operand A.
- out_b_o  out  DATA_W  operand B.
- out_op_o  out  OP_W  forwarded opcode.
- done_cnt_o  out  CNT_W  number of bundles accepted by the ALU.

Behaviour:
- Clock/reset: single clock; reset is synchronous and active-low (rst_ni low at a rising edge of clk_i).
- Reset values: state IDLE; out_valid_o=0; out_a_o=0; out_b_o=0; out_op_o=0; mem_addr_o=0; done_cnt_o=0; internal address latches=0.
- req_ready_o is combinational: 1 in IDLE, or in VALID when out_ready_i=1. It is 0 while reset is asserted.
- States: IDLE, RD_A, RD_B, VALID.
- IDLE:
  - mem_addr_o=0.
  - On a req_valid_i & req_ready_o edge, latch addr_a, addr_b and op, then go to RD_A.
- RD_A:
  - mem_addr_o=latched addr_a.
  - At the edge, capture mem_dato_i into out_a_o.
  - If addr_a==addr_b, also capture the same word into out_b_o and go directly to VALID (same-address shortcut).
  - Otherwise go to RD_B.
- RD_B:
  - mem_addr_o=latched addr_b.
  - At the edge, capture mem_dato_i into out_b_o and go to VALID.
- VALID:
  - out_valid_o=1; mem_addr_o=0.
  - out_a_o, out_b_o and out_op_o are held stable until handshake.
  - On an out_ready_i edge: done_cnt_o increments (wraps 2^CNT_W-1 -> 0).
    - If req_valid_i=1 in the same cycle, latch the new request and go to RD_A (back-to-back, no bubble in IDLE).
    - Otherwise go to IDLE.
  - out_valid_o is never dropped without a handshake.
- Latency: request accepted at edge E. out_valid_o is high after edge E+2 (distinct addresses) or E+1 (equal addresses).
- Throughput:
  - Distinct addresses: one bundle per 3 cycles at best (RD_A, RD_B, VALID).
  - Equal addresses: one bundle per 2 cycles.
- Data width: no sign or width manipulation. Words are passed bit-exact; negative values stay two's complement.
- Addresses: values are never checked; all 8 addresses are legal.
- Request inputs are ignored while req_ready_o=0; the requester must hold them.
- Reset mid-operation (any state): abort; no bundle is produced and done_cnt_o clears.
- Opcode: out_op_o updates when the request is latched, but the downstream side treats it as meaningful only while out_valid_o=1.

Decomposition:
- Shared package/include holds:
  - state encoding constants IDLE=2'd0, RD_A=2'd1, RD_B=2'd2, VALID=2'd3;
  - default widths DATA_W, ADDR_W, OP_W.
- No sub-module is needed. FSM, latches and counter live in one module. The wrapping counter may be a trivial inline always block.

Test Plan:
- The bench uses a behavioural 8x32 ROM with word0=7, word1=10, word3=15, word4=0x1F, word5=0xFFFFFFFB.
- Scenario 1: reset, then req(a=1, b=0, op=2) with out_ready_i=1 -> out_valid_o 2 cycles after accept, A=10, B=7, op=2, done_cnt_o=1.
- Scenario 2: req(a=5, b=4), out_ready_i held 0 for 5 cycles -> A=0xFFFFFFFB, B=0x1F stable and out_valid_o=1 throughout; req_ready_o=0 until out_ready_i rises.
- Scenario 3: req(a=3, b=3) -> RD_B skipped; out_valid_o 1 cycle after accept; A=B=15.
- Scenario 4: continuous req_valid_i and out_ready_i with alternating (1,0)/(0,1) -> bundles every 3 cycles; req_ready_o=1 in each VALID cycle; no IDLE cycle between bundles.
- Scenario 5: rst_ni low during RD_B -> next cycle all outputs 0, state IDLE, no out_valid_o pulse; a following req(a=0, b=1) yields A=7, B=10.
- Scenario 6: 256 back-to-back handshakes -> done_cnt_o wraps 255 -> 0.
